// File: rtl/lotr_ring_inject_if.sv
// Ring request types plus the bus interface of the tile ring injection stage.
// Perf counter ports exist only when LOTR_RING_INJ_PERF_EN is defined.
package lotr_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_RD  = 3'd1,
        OP_WR  = 3'd2,
        OP_RDX = 3'd3,
        OP_WB  = 3'd4,
        OP_INV = 3'd5
    } t_opcode;

    typedef struct packed {
        logic [9:0]  requestor;
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_ring_req;

endpackage

interface lotr_ring_inject_if #(
    parameter int unsigned FIFO_DEPTH = 4
);
    import lotr_pkg::*;

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic          LclReqValidQ502H;
    logic          LclReqReadyQ502H;
    logic [9:0]    LclReqRequestorQ502H;
    t_opcode       LclReqOpcodeQ502H;
    logic [31:0]   LclReqAddressQ502H;
    logic [31:0]   LclReqDataQ502H;

    logic          RingInValidQ502H;
    logic [9:0]    RingInRequestorQ502H;
    t_opcode       RingInOpcodeQ502H;
    logic [31:0]   RingInAddressQ502H;
    logic [31:0]   RingInDataQ502H;

    logic          RingOutValidQ503H;
    logic [9:0]    RingOutRequestorQ503H;
    t_opcode       RingOutOpcodeQ503H;
    logic [31:0]   RingOutAddressQ503H;
    logic [31:0]   RingOutDataQ503H;

    logic [CW-1:0] InjFifoCountQ503H;
    logic          InjStarvedQ503H;

`ifdef LOTR_RING_INJ_PERF_EN
    logic [15:0]   PerfInjCntQ503H;
    logic [15:0]   PerfPassCntQ503H;

    modport slave (
        input  LclReqValidQ502H, LclReqRequestorQ502H, LclReqOpcodeQ502H,
               LclReqAddressQ502H, LclReqDataQ502H,
               RingInValidQ502H, RingInRequestorQ502H, RingInOpcodeQ502H,
               RingInAddressQ502H, RingInDataQ502H,
        output LclReqReadyQ502H,
               RingOutValidQ503H, RingOutRequestorQ503H, RingOutOpcodeQ503H,
               RingOutAddressQ503H, RingOutDataQ503H,
               InjFifoCountQ503H, InjStarvedQ503H,
               PerfInjCntQ503H, PerfPassCntQ503H
    );

    modport master (
        output LclReqValidQ502H, LclReqRequestorQ502H, LclReqOpcodeQ502H,
               LclReqAddressQ502H, LclReqDataQ502H,
               RingInValidQ502H, RingInRequestorQ502H, RingInOpcodeQ502H,
               RingInAddressQ502H, RingInDataQ502H,
        input  LclReqReadyQ502H,
               RingOutValidQ503H, RingOutRequestorQ503H, RingOutOpcodeQ503H,
               RingOutAddressQ503H, RingOutDataQ503H,
               InjFifoCountQ503H, InjStarvedQ503H,
               PerfInjCntQ503H, PerfPassCntQ503H
    );
`else
    modport slave (
        input  LclReqValidQ502H, LclReqRequestorQ502H, LclReqOpcodeQ502H,
               LclReqAddressQ502H, LclReqDataQ502H,
               RingInValidQ502H, RingInRequestorQ502H, RingInOpcodeQ502H,
               RingInAddressQ502H, RingInDataQ502H,
        output LclReqReadyQ502H,
               RingOutValidQ503H, RingOutRequestorQ503H, RingOutOpcodeQ503H,
               RingOutAddressQ503H, RingOutDataQ503H,
               InjFifoCountQ503H, InjStarvedQ503H
    );

    modport master (
        output LclReqValidQ502H, LclReqRequestorQ502H, LclReqOpcodeQ502H,
               LclReqAddressQ502H, LclReqDataQ502H,
               RingInValidQ502H, RingInRequestorQ502H, RingInOpcodeQ502H,
               RingInAddressQ502H, RingInDataQ502H,
        input  LclReqReadyQ502H,
               RingOutValidQ503H, RingOutRequestorQ503H, RingOutOpcodeQ503H,
               RingOutAddressQ503H, RingOutDataQ503H,
               InjFifoCountQ503H, InjStarvedQ503H
    );
`endif

endinterface

// File: rtl/lotr_ring_inject.sv
// Tile ring output stage: forwards ring traffic with priority and injects queued local requests
// into empty slots. LOTR_RING_INJ_PERF_EN adds saturating inject/pass-through slot counters.
module lotr_ring_inject
    import lotr_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic               QClk,
    input  logic               RstQnnnL,
    input  logic [7:0]         CoreID,
    lotr_ring_inject_if.slave  ring_if
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PEND   = 2'd1,
        S_STARVE = 2'd2
    } t_state;

    t_ring_req     mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    t_ring_req     out_q, out_d;
    logic          out_vld_q, out_vld_d;

    t_state        state_q, state_d;
    logic [SW-1:0] wait_q, wait_d;
    logic          starved_q, starved_d;

    t_ring_req     lcl_req;
    t_ring_req     ring_req;
    t_ring_req     head_req;
    logic          push;
    logic          pop;
    logic          ring_busy;
    logic          fifo_empty;

    // CoreID is carried for the tile's static configuration only; no logic consumes it here.
    logic          unused_core_id;
    assign unused_core_id = ^CoreID;

    assign lcl_req  = '{requestor: ring_if.LclReqRequestorQ502H,
                        opcode:    ring_if.LclReqOpcodeQ502H,
                        address:   ring_if.LclReqAddressQ502H,
                        data:      ring_if.LclReqDataQ502H};
    assign ring_req = '{requestor: ring_if.RingInRequestorQ502H,
                        opcode:    ring_if.RingInOpcodeQ502H,
                        address:   ring_if.RingInAddressQ502H,
                        data:      ring_if.RingInDataQ502H};

    assign head_req   = mem_q[rd_ptr_q];
    assign fifo_empty = (count_q == '0);
    assign ring_busy  = ring_if.RingInValidQ502H;
    assign push       = ring_if.LclReqValidQ502H & ready_q;
    assign pop        = ~ring_busy & ~fifo_empty;

    // FIFO bookkeeping and slot selection; ring traffic always takes the slot.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        out_d     = out_q;
        out_vld_d = 1'b0;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (ring_busy) begin
            out_d     = ring_req;
            out_vld_d = 1'b1;
        end else if (pop) begin
            out_d     = head_req;
            out_vld_d = 1'b1;
        end

        ready_d = (count_d != CW'(FIFO_DEPTH));
    end

    // Payload storage is not reset; only pointers and count define contents.
    always_ff @(posedge QClk) begin
        if (push) mem_q[wr_ptr_q] <= lcl_req;
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            out_q     <= out_d;
            out_vld_q <= out_vld_d;
        end
    end

    // Head wait tracking: state register.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            starved_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            starved_q <= starved_d;
        end
    end

    // Head wait tracking: next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (push) state_d = S_PEND;
            end
            S_PEND, S_STARVE: begin
                if (pop)
                    state_d = (count_d != '0) ? S_PEND : S_IDLE;
                else if (wait_d == SW'(STARVE_LIMIT))
                    state_d = S_STARVE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Head wait tracking: counter and starvation flag; the counter saturates at the limit.
    always_comb begin
        wait_d    = wait_q;
        starved_d = 1'b0;
        unique case (state_q)
            S_PEND, S_STARVE: begin
                if (pop)
                    wait_d = '0;
                else if (wait_q != SW'(STARVE_LIMIT))
                    wait_d = wait_q + SW'(1);
            end
            default: wait_d = '0;
        endcase
        starved_d = (state_d == S_STARVE);
    end

    assign ring_if.LclReqReadyQ502H      = ready_q;
    assign ring_if.RingOutValidQ503H     = out_vld_q;
    assign ring_if.RingOutRequestorQ503H = out_q.requestor;
    assign ring_if.RingOutOpcodeQ503H    = out_q.opcode;
    assign ring_if.RingOutAddressQ503H   = out_q.address;
    assign ring_if.RingOutDataQ503H      = out_q.data;
    assign ring_if.InjFifoCountQ503H     = count_q;
    assign ring_if.InjStarvedQ503H       = starved_q;

`ifdef LOTR_RING_INJ_PERF_EN
    logic [15:0] perf_inj_q, perf_inj_d;
    logic [15:0] perf_pass_q, perf_pass_d;

    // Saturating counts of output slots sourced from the FIFO and from the ring.
    always_comb begin
        perf_inj_d  = perf_inj_q;
        perf_pass_d = perf_pass_q;
        if (ring_busy && (perf_pass_q != 16'hFFFF)) perf_pass_d = perf_pass_q + 16'd1;
        if (pop && (perf_inj_q != 16'hFFFF))        perf_inj_d  = perf_inj_q + 16'd1;
    end

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            perf_inj_q  <= '0;
            perf_pass_q <= '0;
        end else begin
            perf_inj_q  <= perf_inj_d;
            perf_pass_q <= perf_pass_d;
        end
    end

    assign ring_if.PerfInjCntQ503H  = perf_inj_q;
    assign ring_if.PerfPassCntQ503H = perf_pass_q;
`endif

endmodule

// File: tb/tb_lotr_ring_inject.sv
// Self-checking bench for lotr_ring_inject: queue-based slot model checked every cycle plus directed scenarios.
module tb_lotr_ring_inject;
    import lotr_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned LIMIT = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] core_id = 8'h05;
    bit         cmp_en = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    lotr_ring_inject_if #(.FIFO_DEPTH(DEPTH)) bus ();

    lotr_ring_inject #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .QClk     (clk),
        .RstQnnnL (rst_n),
        .CoreID   (core_id),
        .ring_if  (bus)
    );

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the slot goes to the ring if valid, else to the oldest queued request.
    t_ring_req mq[$];
    t_ring_req m_out;
    bit        m_vld;
    int        m_wait;
    bit        m_starved;

    always @(posedge clk or negedge rst_n) begin : model
        bit        had_head;
        bit        accept;
        t_ring_req lreq;
        t_ring_req rreq;
        if (!rst_n) begin
            mq.delete();
            m_out     = '0;
            m_vld     = 1'b0;
            m_wait    = 0;
            m_starved = 1'b0;
        end else begin
            had_head = (mq.size() > 0);
            accept   = bus.LclReqValidQ502H && (mq.size() < DEPTH);
            lreq = '{requestor: bus.LclReqRequestorQ502H, opcode: bus.LclReqOpcodeQ502H,
                     address: bus.LclReqAddressQ502H, data: bus.LclReqDataQ502H};
            rreq = '{requestor: bus.RingInRequestorQ502H, opcode: bus.RingInOpcodeQ502H,
                     address: bus.RingInAddressQ502H, data: bus.RingInDataQ502H};
            if (bus.RingInValidQ502H) begin
                m_out = rreq;
                m_vld = 1'b1;
            end else if (had_head) begin
                m_out = mq.pop_front();
                m_vld = 1'b1;
            end else begin
                m_vld = 1'b0;
            end
            if (had_head && bus.RingInValidQ502H) m_wait++;
            else                                  m_wait = 0;
            m_starved = (m_wait >= LIMIT);
            if (accept) mq.push_back(lreq);
        end
    end

    always @(negedge clk) begin : compare
        t_ring_req dut_out;
        if (rst_n && cmp_en) begin
            dut_out = '{requestor: bus.RingOutRequestorQ503H, opcode: bus.RingOutOpcodeQ503H,
                        address: bus.RingOutAddressQ503H, data: bus.RingOutDataQ503H};
            check("ring_out_valid", 80'(bus.RingOutValidQ503H), 80'(m_vld));
            check("ring_out_payload", 80'(dut_out), 80'(m_out));
            check("inj_fifo_count", 80'(bus.InjFifoCountQ503H), 80'(mq.size()));
            check("lcl_req_ready", 80'(bus.LclReqReadyQ502H), 80'(mq.size() != DEPTH));
            check("inj_starved", 80'(bus.InjStarvedQ503H), 80'(m_starved));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ring(input bit v, input logic [31:0] a);
        bus.RingInValidQ502H     = v;
        bus.RingInRequestorQ502H = 10'h3F0;
        bus.RingInOpcodeQ502H    = OP_RD;
        bus.RingInAddressQ502H   = a;
        bus.RingInDataQ502H      = a ^ 32'h5A5A_0000;
    endtask

    task automatic lcl(input bit v, input logic [31:0] a, input logic [31:0] d);
        bus.LclReqValidQ502H     = v;
        bus.LclReqRequestorQ502H = {core_id, 2'd1};
        bus.LclReqOpcodeQ502H    = OP_WR;
        bus.LclReqAddressQ502H   = a;
        bus.LclReqDataQ502H      = d;
    endtask

    initial begin
        lcl(1'b0, 32'h0, 32'h0);
        ring(1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_valid", 80'(bus.RingOutValidQ503H), 80'(0));
        check("reset_count", 80'(bus.InjFifoCountQ503H), 80'(0));
        check("reset_ready", 80'(bus.LclReqReadyQ502H), 80'(1));
        check("reset_starved", 80'(bus.InjStarvedQ503H), 80'(0));
        check("reset_address", 80'(bus.RingOutAddressQ503H), 80'(0));
        cmp_en = 1'b1;

        // Empty-ring inject: accepted at N, on the ring at N+1.
        lcl(1'b1, 32'h44, 32'hDEAD);
        step();
        check("inject_count_after_push", 80'(bus.InjFifoCountQ503H), 80'(1));
        check("inject_valid_after_push", 80'(bus.RingOutValidQ503H), 80'(0));
        lcl(1'b0, 32'h0, 32'h0);
        step();
        check("inject_valid", 80'(bus.RingOutValidQ503H), 80'(1));
        check("inject_address", 80'(bus.RingOutAddressQ503H), 80'(32'h44));
        check("inject_data", 80'(bus.RingOutDataQ503H), 80'(32'hDEAD));
        check("inject_count_drained", 80'(bus.InjFifoCountQ503H), 80'(0));

        // Pass-through priority over a queued request.
        lcl(1'b1, 32'h200, 32'h2222);
        ring(1'b1, 32'h0F0);
        step();
        lcl(1'b0, 32'h0, 32'h0);
        ring(1'b1, 32'h100);
        step();
        check("pass_address", 80'(bus.RingOutAddressQ503H), 80'(32'h100));
        check("pass_data", 80'(bus.RingOutDataQ503H), 80'(32'h5A5A_0100));
        check("pass_count_held", 80'(bus.InjFifoCountQ503H), 80'(1));
        ring(1'b0, 32'h0);
        step();
        check("pass_then_inject_addr", 80'(bus.RingOutAddressQ503H), 80'(32'h200));
        check("pass_then_inject_count", 80'(bus.InjFifoCountQ503H), 80'(0));
        step();
        check("idle_valid_low", 80'(bus.RingOutValidQ503H), 80'(0));
        check("idle_payload_hold", 80'(bus.RingOutAddressQ503H), 80'(32'h200));

        // Full FIFO: 4 accepted, a 5th is held off, then strict order on drain.
        for (int i = 0; i < 4; i++) begin
            lcl(1'b1, 32'h300 + 32'(i), 32'h3000 + 32'(i));
            ring(1'b1, 32'h1000 + 32'(i));
            step();
        end
        check("full_ready", 80'(bus.LclReqReadyQ502H), 80'(0));
        check("full_count", 80'(bus.InjFifoCountQ503H), 80'(4));
        lcl(1'b1, 32'h3FF, 32'h3FFF);
        ring(1'b1, 32'h1010);
        step();
        step();
        check("full_fifth_rejected", 80'(bus.InjFifoCountQ503H), 80'(4));
        lcl(1'b0, 32'h0, 32'h0);
        ring(1'b0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("full_drain_order", 80'(bus.RingOutAddressQ503H), 80'(32'h300 + 32'(i)));
        end
        check("full_drained", 80'(bus.InjFifoCountQ503H), 80'(0));

        // Starvation after LIMIT consecutive blocked cycles.
        lcl(1'b1, 32'h500, 32'h5555);
        ring(1'b1, 32'h2000);
        step();
        lcl(1'b0, 32'h0, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            ring(1'b1, 32'h2000 + 32'(i));
            step();
            if (i == 7) check("starve_not_yet", 80'(bus.InjStarvedQ503H), 80'(0));
            if (i == 8) check("starve_asserted", 80'(bus.InjStarvedQ503H), 80'(1));
        end
        ring(1'b0, 32'h0);
        step();
        check("starve_cleared", 80'(bus.InjStarvedQ503H), 80'(0));
        check("starve_head_out", 80'(bus.RingOutAddressQ503H), 80'(32'h500));

        // Simultaneous push/pop keeps count at 2.
        lcl(1'b1, 32'h600, 32'h6000);
        ring(1'b1, 32'h3000);
        step();
        lcl(1'b1, 32'h601, 32'h6001);
        step();
        ring(1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            lcl(1'b1, 32'h610 + 32'(i), 32'h6100 + 32'(i));
            step();
            check("pushpop_count", 80'(bus.InjFifoCountQ503H), 80'(2));
            check("pushpop_valid", 80'(bus.RingOutValidQ503H), 80'(1));
            check("pushpop_addr", 80'(bus.RingOutAddressQ503H),
                  80'((i < 2) ? (32'h600 + 32'(i)) : (32'h610 + 32'(i - 2))));
        end
        lcl(1'b0, 32'h0, 32'h0);
        step();
        step();
        check("pushpop_drained", 80'(bus.InjFifoCountQ503H), 80'(0));

        // Reset mid-operation drops queued requests.
        for (int i = 0; i < 3; i++) begin
            lcl(1'b1, 32'h700 + 32'(i), 32'h7000 + 32'(i));
            ring(1'b1, 32'h4000 + 32'(i));
            step();
        end
        check("midrst_count_before", 80'(bus.InjFifoCountQ503H), 80'(3));
        lcl(1'b0, 32'h0, 32'h0);
        ring(1'b0, 32'h0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_count", 80'(bus.InjFifoCountQ503H), 80'(0));
        check("midrst_valid", 80'(bus.RingOutValidQ503H), 80'(0));
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_output", 80'(bus.RingOutValidQ503H), 80'(0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
